// File: rtl/voting_pkg.sv
// Shared definitions for the voting session controller: machine mode
// encodings, controller states and the candidate count.
package voting_pkg;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_VOTE   = 2'd1;
  localparam logic [1:0] MODE_RESULT = 2'd2;

  localparam int NUM_CAND = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_BALLOT,
    ST_CAST,
    ST_REL_DONE,
    ST_REL_RETRY,
    ST_CLOSED
  } state_t;

  // Mode presented to the voting machine while the controller sits in state s.
  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      ST_IDLE:   mode_of = MODE_IDLE;
      ST_CLOSED: mode_of = MODE_RESULT;
      default:   mode_of = MODE_VOTE;
    endcase
  endfunction

endpackage

// File: rtl/ballot_qualifier.sv
// Qualifies raw booth buttons while a ballot is open: a one-hot pattern held
// for HOLD_CYCLES consecutive cycles is a vote, several buttons at once is an
// invalid ballot, and TIMEOUT_CYCLES idle cycles void the ballot.
// Outputs are combinational; the controller registers everything it drives out.
module ballot_qualifier
  import voting_pkg::*;
#(
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                active,
  input  logic [NUM_CAND-1:0] btn,
  output logic [NUM_CAND-1:0] valid_vote,
  output logic                invalid,
  output logic                timeout
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_CAND-1:0] btn_prev_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic [TO_W-1:0]     idle_reg;
  logic [HOLD_W:0]     hold_next;
  logic [TO_W:0]       idle_next;
  logic                one_hot;
  logic                btn_zero;

  assign btn_zero = (btn == '0);
  assign one_hot  = !btn_zero && ((btn & (btn - NUM_CAND'(1))) == '0);

  // The hold count is the number of consecutive cycles the current one-hot
  // pattern has been seen, this cycle included; any change restarts it.
  always_comb begin
    hold_next = '0;
    if (one_hot) begin
      if (btn == btn_prev_reg) hold_next = {1'b0, hold_reg} + 1'b1;
      else                     hold_next = (HOLD_W + 1)'(1);
    end
    idle_next = btn_zero ? {1'b0, idle_reg} + 1'b1 : '0;
  end

  assign valid_vote = (active && one_hot && hold_next >= (HOLD_W + 1)'(HOLD_CYCLES)) ? btn : '0;
  assign invalid    = active && !btn_zero && !one_hot;
  assign timeout    = active && btn_zero && idle_next >= (TO_W + 1)'(TIMEOUT_CYCLES);

  // Counters only run while the ballot is open, so each ballot starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev_reg <= '0;
      hold_reg     <= '0;
      idle_reg     <= '0;
    end else begin
      btn_prev_reg <= btn;
      if (!active) begin
        hold_reg <= '0;
        idle_reg <= '0;
      end else begin
        hold_reg <= (hold_next >= (HOLD_W + 1)'(HOLD_CYCLES)) ? HOLD_W'(HOLD_CYCLES)
                                                              : hold_next[HOLD_W-1:0];
        idle_reg <= (idle_next >= (TO_W + 1)'(TIMEOUT_CYCLES)) ? TO_W'(TIMEOUT_CYCLES)
                                                              : idle_next[TO_W-1:0];
      end
    end
  end

endmodule

// File: rtl/voting_session_ctrl.sv
// Session controller for the three-candidate voting machine. Sequences the
// machine mode and turns qualified button presses into one-cycle vote strobes,
// one vote per booth unlock. Every output is a register loaded from the
// next-state decode so outputs line up with the state they describe.
module voting_session_ctrl
  import voting_pkg::*;
#(
  parameter int MAX_VOTERS     = 200,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_election,
  input  logic             end_election,
  input  logic             clear_session,
  input  logic             booth_unlock,
  input  logic [2:0]       btn,
  output logic [1:0]       mode,
  output logic             in_candidate_1,
  output logic             in_candidate_2,
  output logic             in_candidate_3,
  output logic             booth_ready,
  output logic             vote_ack,
  output logic             invalid_ballot,
  output logic             ballot_timeout,
  output logic             session_closed,
  output logic [CNT_W-1:0] votes_cast
);

  state_t              state_reg, state_next;
  logic                end_pending_reg, end_pending_next;
  logic [CNT_W-1:0]    votes_reg, votes_next;
  logic [1:0]          mode_reg;
  logic [NUM_CAND-1:0] cand_reg, cand_next;
  logic                ack_reg, ack_next;
  logic                invalid_reg, invalid_next;
  logic                timeout_reg, timeout_next;
  logic                ready_reg;
  logic                closed_reg;
  logic [NUM_CAND-1:0] valid_vote;
  logic                q_invalid;
  logic                q_timeout;

  ballot_qualifier #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_qual (
    .clk       (clk),
    .reset_n   (reset_n),
    .active    (state_reg == ST_BALLOT),
    .btn       (btn),
    .valid_vote(valid_vote),
    .invalid   (q_invalid),
    .timeout   (q_timeout)
  );

  // Next-state decode plus the values the output registers will take.
  always_comb begin
    state_next       = state_reg;
    end_pending_next = end_pending_reg;
    votes_next       = votes_reg;
    cand_next        = '0;
    ack_next         = 1'b0;
    invalid_next     = 1'b0;
    timeout_next     = 1'b0;

    // An end request during a ballot waits until the booth is released.
    if (end_election && (state_reg == ST_BALLOT || state_reg == ST_CAST ||
                         state_reg == ST_REL_DONE || state_reg == ST_REL_RETRY))
      end_pending_next = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (start_election) begin
          state_next       = ST_ARMED;
          votes_next       = '0;
          end_pending_next = 1'b0;
        end
      end
      ST_ARMED: begin
        if (end_pending_reg || end_election)          state_next = ST_CLOSED;
        else if (votes_reg == CNT_W'(MAX_VOTERS))     state_next = ST_CLOSED;
        else if (booth_unlock)                        state_next = ST_BALLOT;
      end
      ST_BALLOT: begin
        if (valid_vote != '0) begin
          state_next = ST_CAST;
          cand_next  = valid_vote;
          ack_next   = 1'b1;
          votes_next = (votes_reg == '1) ? votes_reg : votes_reg + 1'b1;
        end else if (q_invalid) begin
          state_next   = ST_REL_RETRY;
          invalid_next = 1'b1;
        end else if (q_timeout) begin
          state_next   = ST_ARMED;
          timeout_next = 1'b1;
        end
      end
      ST_CAST:      state_next = ST_REL_DONE;
      ST_REL_DONE:  if (btn == '0) state_next = ST_ARMED;
      ST_REL_RETRY: if (btn == '0) state_next = ST_BALLOT;
      ST_CLOSED: begin
        end_pending_next = 1'b0;
        if (clear_session) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any ballot without a strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      end_pending_reg <= 1'b0;
      votes_reg       <= '0;
      mode_reg        <= MODE_IDLE;
      cand_reg        <= '0;
      ack_reg         <= 1'b0;
      invalid_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
      ready_reg       <= 1'b0;
      closed_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      end_pending_reg <= end_pending_next;
      votes_reg       <= votes_next;
      mode_reg        <= mode_of(state_next);
      cand_reg        <= cand_next;
      ack_reg         <= ack_next;
      invalid_reg     <= invalid_next;
      timeout_reg     <= timeout_next;
      ready_reg       <= (state_next == ST_BALLOT) || (state_next == ST_REL_RETRY);
      closed_reg      <= (state_next == ST_CLOSED);
    end
  end

  assign mode           = mode_reg;
  assign in_candidate_1 = cand_reg[0];
  assign in_candidate_2 = cand_reg[1];
  assign in_candidate_3 = cand_reg[2];
  assign booth_ready    = ready_reg;
  assign vote_ack       = ack_reg;
  assign invalid_ballot = invalid_reg;
  assign ballot_timeout = timeout_reg;
  assign session_closed = closed_reg;
  assign votes_cast     = votes_reg;

endmodule

// File: tb/tb_voting_session_ctrl.sv
// Directed bench for voting_session_ctrl with small limits
// (MAX_VOTERS=3, HOLD_CYCLES=2, TIMEOUT_CYCLES=20).
module tb_voting_session_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start_election, end_election, clear_session, booth_unlock;
  logic [2:0] btn;
  logic [1:0] mode;
  logic       in_candidate_1, in_candidate_2, in_candidate_3;
  logic       booth_ready, vote_ack, invalid_ballot, ballot_timeout, session_closed;
  logic [7:0] votes_cast;

  int checks = 0;
  int errors = 0;
  int cnt_c1 = 0, cnt_c2 = 0, cnt_c3 = 0, cnt_ack = 0;

  voting_session_ctrl #(
    .MAX_VOTERS(3), .HOLD_CYCLES(2), .TIMEOUT_CYCLES(20), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .start_election(start_election), .end_election(end_election),
    .clear_session(clear_session), .booth_unlock(booth_unlock), .btn(btn),
    .mode(mode), .in_candidate_1(in_candidate_1), .in_candidate_2(in_candidate_2),
    .in_candidate_3(in_candidate_3), .booth_ready(booth_ready), .vote_ack(vote_ack),
    .invalid_ballot(invalid_ballot), .ballot_timeout(ballot_timeout),
    .session_closed(session_closed), .votes_cast(votes_cast)
  );

  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle; tests compare deltas against snapshots.
  always @(negedge clk) begin
    cnt_c1  += int'(in_candidate_1);
    cnt_c2  += int'(in_candidate_2);
    cnt_c3  += int'(in_candidate_3);
    cnt_ack += int'(vote_ack);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();  start_election = 1; tick(1); start_election = 0; endtask
  task automatic pulse_end();    end_election   = 1; tick(1); end_election   = 0; endtask
  task automatic pulse_clear();  clear_session  = 1; tick(1); clear_session  = 0; endtask
  task automatic pulse_unlock(); booth_unlock   = 1; tick(1); booth_unlock   = 0; endtask

  // Unlock, hold b for HOLD_CYCLES, release and return to ARMED.
  task automatic cast_vote(input logic [2:0] b);
    pulse_unlock();
    btn = b; tick(2);
    btn = 3'b000; tick(2);
  endtask

  task automatic test_reset();
    reset_n = 0; tick(3);
    checks++;
    if ({mode, booth_ready, session_closed, votes_cast} !== 12'h000 ||
        {in_candidate_1, in_candidate_2, in_candidate_3, vote_ack, invalid_ballot, ballot_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state mode=%0d ready=%0b closed=%0b votes=%0d expected all zero",
               mode, booth_ready, session_closed, votes_cast);
    end
    reset_n = 1; tick(2);
    $display("reset released: mode=%0d votes=%0d", mode, votes_cast);
  endtask

  task automatic test_basic_vote();
    int c1;
    c1 = cnt_c1;
    pulse_start();
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL basic_mode_armed got %0d expected 1", mode); end
    pulse_unlock();
    checks++; if (booth_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b expected 1", booth_ready); end
    btn = 3'b001; tick(2);
    checks++;
    if ({in_candidate_1, vote_ack} !== 2'b11 || votes_cast !== 8'd1) begin
      errors++;
      $display("FAIL basic_cast c1=%0b ack=%0b votes=%0d expected 1 1 1", in_candidate_1, vote_ack, votes_cast);
    end
    btn = 3'b000; tick(2);
    checks++; if (cnt_c1 - c1 !== 1) begin errors++; $display("FAIL basic_c1_pulses got %0d expected 1", cnt_c1 - c1); end
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL basic_mode_after got %0d expected 1", mode); end
    pulse_end();
    checks++;
    if (mode !== 2'd2 || session_closed !== 1'b1) begin
      errors++; $display("FAIL basic_closed mode=%0d closed=%0b expected 2 1", mode, session_closed);
    end
    pulse_clear();
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL basic_idle got %0d expected 0", mode); end
    $display("basic vote: votes=%0d c1 pulses=%0d", votes_cast, cnt_c1 - c1);
  endtask

  task automatic test_long_hold();
    int c1, c2, c3;
    c1 = cnt_c1; c2 = cnt_c2; c3 = cnt_c3;
    pulse_start();
    checks++; if (votes_cast !== 8'd0) begin errors++; $display("FAIL hold_votes_zero got %0d expected 0", votes_cast); end
    pulse_unlock();
    btn = 3'b010; tick(20);
    checks++; if (cnt_c2 - c2 !== 1) begin errors++; $display("FAIL hold_single_pulse got %0d expected 1", cnt_c2 - c2); end
    checks++; if (booth_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_drop got %0b expected 0", booth_ready); end
    pulse_unlock();
    tick(3);
    checks++; if (cnt_c2 - c2 !== 1) begin errors++; $display("FAIL hold_unlock_while_held got %0d expected 1", cnt_c2 - c2); end
    btn = 3'b000; tick(2);
    pulse_unlock();
    btn = 3'b010; tick(2);
    btn = 3'b000; tick(2);
    checks++;
    if (cnt_c2 - c2 !== 2 || cnt_c1 - c1 !== 0 || cnt_c3 - c3 !== 0 || votes_cast !== 8'd2) begin
      errors++;
      $display("FAIL hold_second c2=%0d c1=%0d c3=%0d votes=%0d expected 2 0 0 2",
               cnt_c2 - c2, cnt_c1 - c1, cnt_c3 - c3, votes_cast);
    end
    pulse_end(); pulse_clear();
    $display("long hold: c2 pulses=%0d votes=%0d", cnt_c2 - c2, votes_cast);
  endtask

  task automatic test_invalid();
    int c1, c3;
    c1 = cnt_c1; c3 = cnt_c3;
    pulse_start(); pulse_unlock();
    btn = 3'b101; tick(1);
    checks++;
    if (invalid_ballot !== 1'b1 || booth_ready !== 1'b1) begin
      errors++; $display("FAIL invalid_pulse inv=%0b ready=%0b expected 1 1", invalid_ballot, booth_ready);
    end
    tick(1);
    checks++; if (invalid_ballot !== 1'b0) begin errors++; $display("FAIL invalid_width got %0b expected 0", invalid_ballot); end
    btn = 3'b000; tick(1);
    btn = 3'b100; tick(2);
    checks++;
    if (in_candidate_3 !== 1'b1 || votes_cast !== 8'd1) begin
      errors++; $display("FAIL invalid_retry c3=%0b votes=%0d expected 1 1", in_candidate_3, votes_cast);
    end
    btn = 3'b000; tick(2);
    checks++;
    if (cnt_c3 - c3 !== 1 || cnt_c1 - c1 !== 0) begin
      errors++; $display("FAIL invalid_counts c3=%0d c1=%0d expected 1 0", cnt_c3 - c3, cnt_c1 - c1);
    end
    pulse_end(); pulse_clear();
    $display("invalid ballot: retry vote counted, votes=%0d", votes_cast);
  endtask

  task automatic test_timeout();
    int ack;
    ack = cnt_ack;
    pulse_start(); pulse_unlock();
    tick(19);
    checks++;
    if (ballot_timeout !== 1'b0 || booth_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_early to=%0b ready=%0b expected 0 1", ballot_timeout, booth_ready);
    end
    tick(1);
    checks++;
    if (ballot_timeout !== 1'b1 || booth_ready !== 1'b0 || mode !== 2'd1 || votes_cast !== 8'd0) begin
      errors++;
      $display("FAIL timeout_fire to=%0b ready=%0b mode=%0d votes=%0d expected 1 0 1 0",
               ballot_timeout, booth_ready, mode, votes_cast);
    end
    tick(1);
    checks++; if (ballot_timeout !== 1'b0) begin errors++; $display("FAIL timeout_width got %0b expected 0", ballot_timeout); end
    pulse_unlock();
    checks++; if (booth_ready !== 1'b1) begin errors++; $display("FAIL timeout_rearm got %0b expected 1", booth_ready); end
    tick(20);
    checks++; if (cnt_ack - ack !== 0) begin errors++; $display("FAIL timeout_no_vote got %0d expected 0", cnt_ack - ack); end
    pulse_end(); pulse_clear();
    $display("timeout: votes=%0d", votes_cast);
  endtask

  task automatic test_max_voters();
    pulse_start();
    cast_vote(3'b001); cast_vote(3'b010); cast_vote(3'b100);
    tick(1);
    checks++;
    if (session_closed !== 1'b1 || mode !== 2'd2 || votes_cast !== 8'd3) begin
      errors++;
      $display("FAIL max_close closed=%0b mode=%0d votes=%0d expected 1 2 3", session_closed, mode, votes_cast);
    end
    pulse_unlock(); tick(1);
    checks++;
    if (booth_ready !== 1'b0 || mode !== 2'd2) begin
      errors++; $display("FAIL max_unlock_ignored ready=%0b mode=%0d expected 0 2", booth_ready, mode);
    end
    pulse_start();
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL closed_start_ignored got %0d expected 2", mode); end
    pulse_clear();
    $display("max voters: closed after %0d votes", votes_cast);
  endtask

  task automatic test_simultaneous();
    start_election = 1; end_election = 1; tick(1);
    start_election = 0; end_election = 0;
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL sim_start_wins got %0d expected 1", mode); end
    end_election = 1; booth_unlock = 1; tick(1);
    end_election = 0; booth_unlock = 0;
    checks++;
    if (mode !== 2'd2 || booth_ready !== 1'b0) begin
      errors++; $display("FAIL sim_end_wins mode=%0d ready=%0b expected 2 0", mode, booth_ready);
    end
    pulse_clear();
    pulse_start(); pulse_unlock();
    btn = 3'b001; tick(1);
    end_election = 1; tick(1); end_election = 0;
    checks++;
    if (vote_ack !== 1'b1 || votes_cast !== 8'd1) begin
      errors++; $display("FAIL sim_vote_with_end ack=%0b votes=%0d expected 1 1", vote_ack, votes_cast);
    end
    btn = 3'b000; tick(3);
    checks++; if (session_closed !== 1'b1) begin errors++; $display("FAIL sim_close_after got %0b expected 1", session_closed); end
    pulse_clear();
    $display("simultaneous events: votes=%0d", votes_cast);
  endtask

  task automatic test_end_mid_ballot();
    pulse_start(); pulse_unlock();
    pulse_end();
    checks++;
    if (mode !== 2'd1 || booth_ready !== 1'b1) begin
      errors++; $display("FAIL mid_end_keeps_ballot mode=%0d ready=%0b expected 1 1", mode, booth_ready);
    end
    btn = 3'b001; tick(2);
    checks++;
    if (vote_ack !== 1'b1 || votes_cast !== 8'd1) begin
      errors++; $display("FAIL mid_end_vote ack=%0b votes=%0d expected 1 1", vote_ack, votes_cast);
    end
    btn = 3'b000; tick(3);
    checks++;
    if (session_closed !== 1'b1 || mode !== 2'd2) begin
      errors++; $display("FAIL mid_end_close closed=%0b mode=%0d expected 1 2", session_closed, mode);
    end
    pulse_clear();
    $display("end mid ballot: votes=%0d", votes_cast);
  endtask

  task automatic test_reset_mid_ballot();
    int c1;
    c1 = cnt_c1;
    pulse_start(); pulse_unlock();
    btn = 3'b001; tick(1);
    reset_n = 0; #1;
    checks++;
    if (mode !== 2'd0 || booth_ready !== 1'b0 || votes_cast !== 8'd0 || in_candidate_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid mode=%0d ready=%0b votes=%0d c1=%0b expected 0 0 0 0",
               mode, booth_ready, votes_cast, in_candidate_1);
    end
    tick(2);
    btn = 3'b000; reset_n = 1; tick(3);
    checks++; if (cnt_c1 - c1 !== 0) begin errors++; $display("FAIL reset_mid_no_strobe got %0d expected 0", cnt_c1 - c1); end
    $display("reset mid ballot: mode=%0d votes=%0d", mode, votes_cast);
  endtask

  initial begin
    clk = 0; reset_n = 0;
    start_election = 0; end_election = 0; clear_session = 0; booth_unlock = 0; btn = 3'b000;
    test_reset();
    test_basic_vote();
    test_long_hold();
    test_invalid();
    test_timeout();
    test_max_voters();
    test_simultaneous();
    test_end_mid_ballot();
    test_reset_mid_ballot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
